lnl_bus_fabric: RTL and testbench
=================================

Name: lnl_bus_fabric

Overview:
Parametrised address-decode and transaction sequencer between the LnL CPU bus and NSLV memory-mapped slaves (boot ROM, RAM, SPI, future peripherals). It replaces the fixed combinational chip-select/readback mux used so far. It adds per-slave wait states, a slave-ready handshake, a registered read path, an unmapped-address error and a bus timeout. Slave i owns the word addresses i*2^SLOT_W .. (i+1)*2^SLOT_W-1.

Parameters:
ADDR_W, 12, CPU word-address width
DATA_W, 16, data width
NSLV, 4, number of slave regions (index 0 = boot ROM)
SLOT_W, 3, log2 of region size in words; slave offset width
WAIT_CYC, 16'h2010, packed 4 bits per slave, WAIT_CYC[4*i+:4] = fixed wait cycles for slave i
TIMEOUT, 8, maximum ACCESS cycles before error; 0 disables the timeout

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
m_en  in  1  CPU request; sampled only in IDLE
m_rw  in  1  1 = write, 0 = read (same polarity as the CPU rdwr signal)
m_addr  in  ADDR_W  word address
m_wdata  in  DATA_W  write data
m_rdata  out  DATA_W  registered read data; held until the next response
m_ready  out  1  one-cycle completion pulse
m_err  out  1  error flag; valid when m_ready=1
s_sel  out  NSLV  one-hot slave select; held for the whole access
s_we  out  1  latched m_rw
s_addr  out  SLOT_W  latched offset, m_addr[SLOT_W-1:0]
s_wdata  out  DATA_W  latched write data
s_rdata  in  NSLV*DATA_W  packed slave read data; slave i at [DATA_W*i+:DATA_W]
s_ready  in  NSLV  slave ready; tie high for zero-wait slaves

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; s_sel=0; s_we=0; s_addr=0; s_wdata=0; m_ready=0; m_err=0; m_rdata=0; all counters 0. Reset takes effect immediately, including mid-transaction; an interrupted write is abandoned.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if m_en=1, latch m_rw, m_addr and m_wdata, then decode idx = m_addr >> SLOT_W.
  - idx < NSLV: go to ACCESS. Set s_sel = 1<<idx. Load wcnt = WAIT_CYC[idx]. Clear tcnt.
  - idx >= NSLV (unmapped): go to RESP with err=1 and rdata=0. No s_sel is asserted.
- ACCESS (s_sel held, s_* stable), evaluated each cycle in this order:
  - wcnt != 0: decrement wcnt.
  - Otherwise, if s_ready[idx]=1: capture s_rdata slice idx into m_rdata (reads only; writes leave m_rdata unchanged). Set err=0 and go to RESP.
  - Otherwise, if TIMEOUT != 0 and tcnt == TIMEOUT-1: set err=1, m_rdata=0, go to RESP.
  - tcnt increments on every ACCESS cycle.
- Slave write commit: a slave commits the write on the cycle where s_sel[i] & s_we & s_ready[i] holds and wcnt = 0.
- RESP: s_sel=0. m_ready=1 and m_err=err for exactly one cycle, then return to IDLE.
- Latency from the IDLE sampling cycle to m_ready:
  - mapped slave: 2 + WAIT + extra not-ready cycles
  - unmapped address: 1
  - timeout: TIMEOUT + 1
- m_en and m_addr changes during ACCESS or RESP are ignored. If m_en is still high in the IDLE cycle after RESP, a new transaction starts (back-to-back allowed). The CPU drops m_en on seeing m_ready if it wants no further access.
- Partial-width slaves (e.g. 8-bit SPI) zero-extend their data at their own outputs; the fabric passes the full DATA_W.
- Fabric never asserts more than one s_sel bit.
- Design constraint: TIMEOUT must be greater than the maximum WAIT_CYC entry, or the slowest slave always times out.

Test Plan:
(All with default parameters; cycle 0 = the IDLE cycle that samples m_en.)
1. Read, m_addr=0x003, slave0 rdata=0x1234, s_ready=4'hF -> s_sel=0001 and s_addr=3 in cycle 1 only; m_ready=1 in cycle 2 with m_rdata=0x1234, m_err=0.
2. Write, m_addr=0x00A, m_wdata=0xBEEF (slave1, WAIT=1) -> s_sel=0010, s_we=1, s_addr=2, s_wdata=0xBEEF in cycles 1-2; m_ready in cycle 3; m_rdata unchanged.
3. Unmapped m_addr=0x020 -> s_sel stays 0; m_ready=1 and m_err=1 in cycle 1; m_rdata=0.
4. Read 0x011 (slave2) with s_ready[2]=0 held -> s_sel=0100 for exactly 8 cycles; m_ready=1, m_err=1, m_rdata=0 in cycle 9. Repeat with s_ready[2] raised in cycle 4 -> m_ready in cycle 5, m_err=0.
5. Read slave3 (0x01C, WAIT=2); pull rst_n low in cycle 2 -> s_sel=0, m_ready=0, m_rdata=0 without waiting for a clock. After release, the read to 0x003 from test 1 behaves exactly as in test 1.
6. m_en held high; m_addr=0x003 then changed to 0x00B in cycle 1 -> the first access uses slave0 (addr latched); the second access starts in cycle 3 to slave1 with s_addr=3; m_ready pulses in cycles 2 and 6.

Source files
------------

// File: rtl/lnl_bus_fabric_if.sv
// LnL CPU bus plus NSLV slave-side signals, grouped for the bus fabric.
// "slave" is the fabric's view; "master" is the surrounding CPU and slave devices.
interface lnl_bus_fabric_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NSLV   = 4,
  parameter int unsigned SLOT_W = 3
);
  logic                   m_en;
  logic                   m_rw;
  logic [ADDR_W-1:0]      m_addr;
  logic [DATA_W-1:0]      m_wdata;
  logic [DATA_W-1:0]      m_rdata;
  logic                   m_ready;
  logic                   m_err;
  logic [NSLV-1:0]        s_sel;
  logic                   s_we;
  logic [SLOT_W-1:0]      s_addr;
  logic [DATA_W-1:0]      s_wdata;
  logic [NSLV*DATA_W-1:0] s_rdata;
  logic [NSLV-1:0]        s_ready;

  modport slave (
    input  m_en, m_rw, m_addr, m_wdata, s_rdata, s_ready,
    output m_rdata, m_ready, m_err, s_sel, s_we, s_addr, s_wdata
  );

  modport master (
    output m_en, m_rw, m_addr, m_wdata, s_rdata, s_ready,
    input  m_rdata, m_ready, m_err, s_sel, s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/lnl_bus_fabric.sv
// Address decode and transaction sequencer from the LnL CPU bus to NSLV slaves, with
// per-slave wait states, slave-ready handshake, registered read data and a bus timeout.
module lnl_bus_fabric #(
  parameter int unsigned         ADDR_W   = 12,
  parameter int unsigned         DATA_W   = 16,
  parameter int unsigned         NSLV     = 4,
  parameter int unsigned         SLOT_W   = 3,
  parameter logic [4*NSLV-1:0]   WAIT_CYC = 16'h2010,
  parameter int unsigned         TIMEOUT  = 8
) (
  input logic             clk,
  input logic             rst_n,
  lnl_bus_fabric_if.slave bus
);

  localparam int unsigned IdxW  = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int unsigned TcntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic [TcntW-1:0]    tcnt_q, tcnt_d;
  logic [NSLV-1:0]     sel_q, sel_d;
  logic                we_q, we_d;
  logic [SLOT_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;

  logic [ADDR_W-SLOT_W-1:0] idx_full;
  logic [IdxW-1:0]          idx_new;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;

    idx_full = bus.m_addr[ADDR_W-1:SLOT_W];
    idx_new  = idx_full[IdxW-1:0];

    case (state_q)
      StIdle: begin
        if (bus.m_en) begin
          we_d    = bus.m_rw;
          addr_d  = bus.m_addr[SLOT_W-1:0];
          wdata_d = bus.m_wdata;
          if (32'(idx_full) < NSLV) begin
            state_d        = StAccess;
            idx_d          = idx_new;
            sel_d          = '0;
            sel_d[idx_new] = 1'b1;
            wcnt_d         = WAIT_CYC[4*idx_new +: 4];
            tcnt_d         = '0;
          end else begin
            // Unmapped: answer straight away with an error, no slave touched.
            state_d = StResp;
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end

      StAccess: begin
        tcnt_d = tcnt_q + 1'b1;
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else if (bus.s_ready[idx_q]) begin
          if (!we_q) begin
            rdata_d = bus.s_rdata[DATA_W*idx_q +: DATA_W];
          end
          sel_d   = '0;
          ready_d = 1'b1;
          state_d = StResp;
        end else if ((TIMEOUT != 0) && (tcnt_q == TcntW'(TIMEOUT - 1))) begin
          sel_d   = '0;
          rdata_d = '0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign bus.s_sel   = sel_q;
  assign bus.s_we    = we_q;
  assign bus.s_addr  = addr_q;
  assign bus.s_wdata = wdata_q;
  assign bus.m_rdata = rdata_q;
  assign bus.m_ready = ready_q;
  assign bus.m_err   = err_q;

endmodule

// File: tb/tb_lnl_bus_fabric.sv
// Bench for lnl_bus_fabric: directed scenarios, then random transactions checked
// against a latency/memory reference model.
module tb_lnl_bus_fabric;

  localparam int unsigned TMO = 8;

  logic clk;
  logic rst_n;

  lnl_bus_fabric_if #(.ADDR_W(12), .DATA_W(16), .NSLV(4), .SLOT_W(3)) bus ();

  lnl_bus_fabric #(
    .ADDR_W  (12),
    .DATA_W  (16),
    .NSLV    (4),
    .SLOT_W  (3),
    .WAIT_CYC(16'h2010),
    .TIMEOUT (TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave devices: 4 regions x 8 words, preload port plus write commit.
  logic [15:0] smem [32];
  logic [15:0] rmem [32];
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [15:0] ld_data;

  always @(posedge clk) begin
    if (ld_en) begin
      smem[ld_addr] <= ld_data;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (bus.s_sel[i] && bus.s_we && bus.s_ready[i]) begin
          smem[{2'(i), bus.s_addr}] <= bus.s_wdata;
        end
      end
    end
  end

  always_comb begin
    bus.s_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      bus.s_rdata[16*i +: 16] = smem[{2'(i), bus.s_addr}];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int waits [4] = '{0, 1, 0, 2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [15:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en   = 1'b0;
    rmem[a] = d;
  endtask

  // Reference timing: completion on the first access cycle past the wait states where
  // the slave is ready, unless that lies beyond the timeout window.
  function automatic void model(input logic [11:0] addr, input int r, output int lat,
                                output logic err);
    int idx;
    int c;
    idx = int'(addr >> 3);
    if (idx >= 4) begin
      lat = 1;
      err = 1'b1;
      return;
    end
    c = (waits[idx] + 1 > r) ? waits[idx] + 1 : r;
    if (c <= int'(TMO)) begin
      lat = c + 1;
      err = 1'b0;
    end else begin
      lat = int'(TMO) + 1;
      err = 1'b1;
    end
  endfunction

  // One transaction from its IDLE sampling cycle through to the following IDLE cycle.
  task automatic txn(input string tag, input logic rw, input logic [11:0] addr,
                     input logic [15:0] wdata, input int r, input int lat,
                     input logic err, input logic [15:0] rdata, input bit noise);
    logic [3:0] exp_sel;
    bit         mapped;
    mapped  = (addr >> 3) < 12'd4;
    exp_sel = mapped ? (4'b0001 << addr[4:3]) : 4'b0000;
    bus.m_en    = 1'b1;
    bus.m_rw    = rw;
    bus.m_addr  = addr;
    bus.m_wdata = wdata;
    bus.s_ready = (r <= 0) ? 4'hF : 4'h0;
    for (int k = 1; k <= lat; k++) begin
      tick();
      bus.s_ready = (k >= r) ? 4'hF : 4'h0;
      if (noise) begin
        bus.m_en   = 1'($urandom);
        bus.m_addr = 12'($urandom);
      end else begin
        bus.m_en = 1'b0;
      end
      check({tag, "/sel"}, 32'(bus.s_sel), 32'((k < lat) ? exp_sel : 4'b0000));
      if (k < lat && mapped) begin
        check({tag, "/s_addr"}, 32'(bus.s_addr), 32'(addr[2:0]));
        check({tag, "/s_we"}, 32'(bus.s_we), 32'(rw));
        check({tag, "/s_wdata"}, 32'(bus.s_wdata), 32'(wdata));
      end
      check({tag, "/ready"}, 32'(bus.m_ready), 32'(k == lat));
      if (k == lat) begin
        check({tag, "/err"}, 32'(bus.m_err), 32'(err));
        check({tag, "/rdata"}, 32'(bus.m_rdata), 32'(rdata));
      end
    end
    bus.m_en = 1'b0;
    tick();
    bus.s_ready = 4'h0;
    check({tag, "/idle_ready"}, 32'(bus.m_ready), 32'd0);
  endtask

  logic [11:0] addr;
  logic        rw;
  logic [15:0] wd;
  logic [15:0] erd;
  logic [15:0] last;
  logic        err;
  int          r;
  int          lat;

  initial begin
    rst_n       = 1'b0;
    ld_en       = 1'b0;
    ld_addr     = '0;
    ld_data     = '0;
    bus.m_en    = 1'b0;
    bus.m_rw    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.s_ready = 4'h0;

    for (int j = 0; j < 32; j++) preload(5'(j), 16'($urandom));
    preload(5'd3, 16'h1234);
    preload(5'd17, 16'h5A5A);

    // Reset state
    check("rst/sel", 32'(bus.s_sel), 32'd0);
    check("rst/we", 32'(bus.s_we), 32'd0);
    check("rst/s_addr", 32'(bus.s_addr), 32'd0);
    check("rst/s_wdata", 32'(bus.s_wdata), 32'd0);
    check("rst/ready", 32'(bus.m_ready), 32'd0);
    check("rst/err", 32'(bus.m_err), 32'd0);
    check("rst/rdata", 32'(bus.m_rdata), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: zero-wait read of slave 0
    txn("t1", 1'b0, 12'h003, 16'h0000, 0, 2, 1'b0, 16'h1234, 0);
    // 2: write to slave 1 with one wait state; read data holds
    txn("t2", 1'b1, 12'h00A, 16'hBEEF, 0, 3, 1'b0, 16'h1234, 0);
    check("t2/commit", 32'(smem[10]), 32'h0000BEEF);
    rmem[10] = 16'hBEEF;
    // 3: unmapped
    txn("t3", 1'b0, 12'h020, 16'h0000, 0, 1, 1'b1, 16'h0000, 0);
    // 4: slave 2 never ready -> timeout; then ready in cycle 4
    txn("t4a", 1'b0, 12'h011, 16'h0000, 99, 9, 1'b1, 16'h0000, 0);
    txn("t4b", 1'b0, 12'h011, 16'h0000, 4, 5, 1'b0, 16'h5A5A, 0);

    // 5: reset in the middle of a slave-3 read
    bus.m_en    = 1'b1;
    bus.m_rw    = 1'b0;
    bus.m_addr  = 12'h01C;
    bus.s_ready = 4'hF;
    tick();
    bus.m_en = 1'b0;
    tick();
    check("t5/sel_pre", 32'(bus.s_sel), 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5/sel", 32'(bus.s_sel), 32'd0);
    check("t5/ready", 32'(bus.m_ready), 32'd0);
    check("t5/rdata", 32'(bus.m_rdata), 32'd0);
    tick();
    rst_n       = 1'b1;
    bus.s_ready = 4'h0;
    tick();
    txn("t5r", 1'b0, 12'h003, 16'h0000, 0, 2, 1'b0, 16'h1234, 0);

    // 6: back-to-back with m_en held high; address change during access ignored
    bus.m_en    = 1'b1;
    bus.m_rw    = 1'b0;
    bus.m_addr  = 12'h003;
    bus.s_ready = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) bus.m_addr = 12'h00B;
      if (k == 6) bus.m_en = 1'b0;
      check("t6/sel", 32'(bus.s_sel),
            32'((k == 1) ? 4'b0001 : (k == 4 || k == 5) ? 4'b0010 : 4'b0000));
      check("t6/ready", 32'(bus.m_ready), 32'(k == 2 || k == 6));
      if (k == 1 || k == 4) check("t6/s_addr", 32'(bus.s_addr), 32'd3);
      if (k == 2) check("t6/rdata1", 32'(bus.m_rdata), 32'h1234);
      if (k == 6) check("t6/rdata2", 32'(bus.m_rdata), 32'(rmem[11]));
    end
    bus.s_ready = 4'h0;
    last = rmem[11];

    // Random transactions against the reference model
    for (int n = 0; n < 80; n++) begin
      addr = 12'($urandom_range(0, 39));
      rw   = 1'($urandom);
      wd   = 16'($urandom);
      r    = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 4));
      model(addr, r, lat, err);
      if (err) begin
        erd = 16'h0000;
      end else if (rw) begin
        erd = last;
        rmem[addr[4:0]] = wd;
      end else begin
        erd = rmem[addr[4:0]];
      end
      txn("rnd", rw, addr, wd, r, lat, err, erd, 1);
      last = erd;
    end

    for (int j = 0; j < 32; j++) check("mem", 32'(smem[j]), 32'(rmem[j]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
